// File: rtl/inst_encoder.sv
// Instruction encoder: accepts mnemonic + operand fields, builds the 32-bit
// MIPS-style machine word and writes it to sequential instruction-memory
// addresses. Stops accepting once every word has been written, until clear.
module inst_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [25:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2,
        S_FULL = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic [4:0]        r_mnem;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [4:0]        r_shamt;
    logic [25:0]       r_imm;
    logic [31:0]       r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_data;
    logic              r_full;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_legal;

    // Encode the captured request; unused fields are forced to zero per format
    always_comb begin
        w_legal = 1'b1;
        w_word  = 32'd0;
        case (r_mnem)
            5'd0:  w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b100000};    // add
            5'd1:  w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b100010};    // sub
            5'd2:  w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b100100};    // and
            5'd3:  w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b100101};    // or
            5'd4:  w_word = {6'b000000, r_rs, r_rt, r_rd, 5'd0, 6'b100110};    // xor
            5'd5:  w_word = {6'b000000, 5'd0, r_rt, r_rd, r_shamt, 6'b000000}; // sll
            5'd6:  w_word = {6'b000000, 5'd0, r_rt, r_rd, r_shamt, 6'b000010}; // srl
            5'd7:  w_word = {6'b000000, 5'd0, r_rt, r_rd, r_shamt, 6'b000011}; // sra
            5'd8:  w_word = {6'b000000, r_rs, 5'd0, 5'd0, 5'd0, 6'b001000};    // jr
            5'd9:  w_word = {6'b001000, r_rs, r_rt, r_imm[15:0]};              // addi
            5'd10: w_word = {6'b001100, r_rs, r_rt, r_imm[15:0]};              // andi
            5'd11: w_word = {6'b001101, r_rs, r_rt, r_imm[15:0]};              // ori
            5'd12: w_word = {6'b001110, r_rs, r_rt, r_imm[15:0]};              // xori
            5'd13: w_word = {6'b100011, r_rs, r_rt, r_imm[15:0]};              // lw
            5'd14: w_word = {6'b101011, r_rs, r_rt, r_imm[15:0]};              // sw
            5'd15: w_word = {6'b000100, r_rs, r_rt, r_imm[15:0]};              // beq
            5'd16: w_word = {6'b000101, r_rs, r_rt, r_imm[15:0]};              // bne
            5'd17: w_word = {6'b001111, 5'd0, r_rt, r_imm[15:0]};              // lui
            5'd18: w_word = {6'b000010, r_imm};                                // j
            5'd19: w_word = {6'b000011, r_imm};                                // jal
            default: w_legal = 1'b0;
        endcase
    end

    // Control FSM with registered outputs. in_ready is a registered view of
    // IDLE: it drops on accept and rises one cycle after IDLE is re-entered.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_mnem     <= 5'd0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rd       <= 5'd0;
            r_shamt    <= 5'd0;
            r_imm      <= 26'd0;
            r_word     <= 32'd0;
            r_addr     <= '0;
            r_count    <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= 32'd0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (clear) begin
                // Restart: drops any in-flight encode/write and refuses the request
                r_state    <= S_IDLE;
                r_in_ready <= 1'b1;
                r_addr     <= '0;
                r_count    <= '0;
                r_mem_addr <= '0;
                r_full     <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid && r_in_ready) begin
                            r_mnem     <= mnem;
                            r_rs       <= rs;
                            r_rt       <= rt;
                            r_rd       <= rd;
                            r_shamt    <= shamt;
                            r_imm      <= imm;
                            r_in_ready <= 1'b0;
                            r_state    <= S_ENC;
                        end else begin
                            r_in_ready <= 1'b1;
                        end
                    end
                    S_ENC: begin
                        if (w_legal) begin
                            r_word  <= w_word;
                            r_state <= S_WR;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_WR: begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_mem_data <= r_word;
                        r_addr     <= r_addr + 1'b1;
                        r_count    <= r_count + 1'b1;
                        if (r_addr == {ADDR_W{1'b1}}) begin
                            r_full  <= 1'b1;
                            r_state <= S_FULL;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        // FULL: hold until clear or reset
                        r_state <= S_FULL;
                    end
                endcase
            end
        end
    end

    assign in_ready = r_in_ready;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign full     = r_full;
    assign err      = r_err;
    assign count    = r_count;

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the instruction-memory word-address width (depth 2^ADDR_W).
REQ-002 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port resetn, input, 1, the reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clear, input, 1, synchronous restart of the write address, count and error state.
REQ-005 The block SHALL have port in_valid, input, 1, request valid.
REQ-006 The block SHALL have port in_ready, output, 1, request accepted when in_valid & in_ready are sampled high at a clock edge.
REQ-007 The block SHALL have port mnem, input, 5, mnemonic code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 addi, 10 andi, 11 ori, 12 xori, 13 lw, 14 sw, 15 beq, 16 bne, 17 lui, 18 j, 19 jal; codes 20-31 are illegal.
REQ-008 The block SHALL have ports rs, rt, rd and shamt, each input, 5, the register and shift fields.
REQ-009 The block SHALL have port imm, input, 26, where imm[15:0] is the I-type immediate and imm[25:0] is the J-type target.
REQ-010 The block SHALL have port mem_we, output, 1, a one-cycle instruction-memory write strobe.
REQ-011 The block SHALL have port mem_addr, output, ADDR_W, the word address.
REQ-012 The block SHALL have port mem_data, output, 32, the encoded instruction.
REQ-013 The block SHALL have port full, output, 1, asserted when all 2^ADDR_W words have been written.
REQ-014 The block SHALL have port err, output, 1, a sticky illegal-mnemonic flag.
REQ-015 The block SHALL have port count, output, ADDR_W+1, the number of words written since reset or clear.

Function
REQ-016 The block SHALL implement FSM states IDLE, ENC, WR and FULL.
REQ-017 In IDLE, the block SHALL assert in_ready; in all other states in_ready SHALL be low.
REQ-018 IDLE SHALL go to ENC on accept, registering mnem and all fields.
REQ-019 ENC SHALL compute the 32-bit word into a register and go to WR; an illegal mnem SHALL instead set err and return to IDLE with no write.
REQ-020 WR SHALL assert mem_we for exactly one cycle with mem_addr equal to the current address and mem_data equal to the word, then increment the address and count.
REQ-021 WR SHALL go to FULL if the written address was 2^ADDR_W-1; otherwise WR SHALL go to IDLE.
REQ-022 Latency SHALL be: accept at edge N, mem_we high during the cycle following edge N+2, and in_ready high again after edge N+3.
REQ-023 R-type encoding SHALL be {6'b0, rs, rt, rd, shamt, func}, with func as follows: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
REQ-024 For add, sub, and, or and xor, the shamt field SHALL be forced to 0.
REQ-025 For sll, srl and sra, the rs field SHALL be forced to 0.
REQ-026 For jr, the rt, rd and shamt fields SHALL be forced to 0.
REQ-027 I-type encoding SHALL be {op, rs, rt, imm[15:0]}, with op as follows: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111.
REQ-028 For lui, the rs field SHALL be forced to 0.
REQ-029 J-type encoding SHALL be {op, imm[25:0]}, with op 000010 for j and 000011 for jal.
REQ-030 In FULL, in_ready SHALL be low and requests SHALL be ignored until clear or reset.
REQ-031 The address SHALL wrap from 2^ADDR_W-1 to 0, but only a clear SHALL leave FULL.
REQ-032 When clear is high at an edge, the FSM SHALL go to IDLE, address and count SHALL be zeroed, err SHALL be cleared, and any pending ENC/WR write SHALL be discarded.
REQ-033 If clear and in_valid are high at the same edge, clear SHALL win and the request SHALL not be accepted.
REQ-034 mem_data SHALL hold its last value when mem_we is low.

Reset
REQ-035 On resetn low, regardless of the clock, the block SHALL enter IDLE.
REQ-036 During reset, mem_we SHALL be 0, mem_addr SHALL be 0, mem_data SHALL be 0, count SHALL be 0, full SHALL be 0 and err SHALL be 0.
REQ-037 During reset, in_ready SHALL be 1 (IDLE).
REQ-038 Reset during ENC or WR SHALL abort the operation with no write strobe.

Verification
REQ-039 Bench SHALL check: add rs=1 rt=2 rd=3 -> mem_we at N+2, addr 0, data 0x00221820, count 1.
REQ-040 Bench SHALL check: lw rs=1 rt=2 imm=4, then sll rt=3 rd=2 shamt=4 with rs=7 -> 0x8C220004 at addr 0, then 0x00031100 at addr 1 (rs forced 0).
REQ-041 Bench SHALL check: j imm=0x10, then jal imm=0x10 -> 0x08000010, then 0x0C000010.
REQ-042 Bench SHALL check: mnem=25 -> no mem_we, err=1, count unchanged, in_ready returns high; a subsequent clear -> err=0.
REQ-043 Bench SHALL check: ADDR_W=2 with 4 writes -> full=1, in_ready=0, a 5th request is ignored; clear -> IDLE, addr 0, count 0.
REQ-044 Bench SHALL check: resetn pulled low in WR -> no mem_we, all outputs at reset values immediately.
